// File: rtl/frankie_pkg.sv
// Shared definitions for the Frankie CPU kernel-entry logic: FSM encoding,
// the kernel return address and the default vector layout.
package frankie_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_KERNEL = 2'd2
  } irq_state_e;

  localparam logic [15:0] KERNEL_RET_PC  = 16'd255;
  localparam logic [15:0] VEC_BASE_DEF   = 16'd192;
  localparam logic [15:0] VEC_STRIDE_DEF = 16'd4;

  // Kernel entry address for a source; wraps modulo 2^16.
  function automatic logic [15:0] irq_vec(input logic [15:0] base,
                                          input logic [15:0] stride,
                                          input logic [3:0]  id);
    return base + (stride * {12'd0, id});
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest-index set request bit.
module irq_prio_enc #(
  parameter int NUM_SRC = 16
) (
  input  logic [NUM_SRC-1:0] req,
  output logic [3:0]         id,
  output logic               any
);

  // Scanning downward lets the lowest set index be the last assignment.
  always_comb begin
    id  = 4'd0;
    any = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        id  = 4'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller for the Frankie CPU: edge-latched requests, software
// mask, fixed priority, and the IDLE/REQ/KERNEL kernel-entry handshake.
import frankie_pkg::*;

module interrupt_controller #(
  parameter int          NUM_SRC    = 16,
  parameter logic [15:0] VEC_BASE   = VEC_BASE_DEF,
  parameter logic [15:0] VEC_STRIDE = VEC_STRIDE_DEF,
  parameter logic [15:0] MASK_RST   = 16'hFFFF
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [NUM_SRC-1:0] io_in,
  input  logic               mask_wr,
  input  logic [NUM_SRC-1:0] mask_data,
  input  logic               at_boundary,
  input  logic [15:0]        pc,
  input  logic               irq_ack,
  input  logic               kernel_done,
  output logic               irq_req,
  output logic [3:0]         irq_id,
  output logic [15:0]        irq_vector,
  output logic [15:0]        epc,
  output logic               in_kernel,
  output logic [NUM_SRC-1:0] pending,
  output logic [NUM_SRC-1:0] mask,
  output logic [15:0]        irq_count
);

  irq_state_e         state_q, state_d;
  logic [NUM_SRC-1:0] io_q, io_d;
  logic               primed_q, primed_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [3:0]         irq_id_q, irq_id_d;
  logic [15:0]        irq_vector_q, irq_vector_d;
  logic [15:0]        epc_q, epc_d;
  logic [15:0]        irq_count_q, irq_count_d;
  logic               irq_req_q, irq_req_d;
  logic               in_kernel_q, in_kernel_d;

  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] clr;
  logic [3:0]         sel_id;
  logic               sel_any;

  assign eligible = pending_q & mask_q;
  // io_q is zero straight out of reset, so the first sample after release
  // is only used to learn the line levels; a line held high does not post.
  assign rise     = primed_q ? (io_in & ~io_q) : '0;

  irq_prio_enc #(
    .NUM_SRC(NUM_SRC)
  ) u_prio_enc (
    .req (eligible),
    .id  (sel_id),
    .any (sel_any)
  );

  always_comb begin
    state_d      = state_q;
    io_d         = io_in;
    primed_d     = 1'b1;
    mask_d       = mask_q;
    irq_id_d     = irq_id_q;
    irq_vector_d = irq_vector_q;
    epc_d        = epc_q;
    irq_count_d  = irq_count_q;
    clr          = '0;

    if (mask_wr) begin
      mask_d = mask_data;
    end

    case (state_q)
      ST_IDLE: begin
        if (sel_any && at_boundary) begin
          irq_id_d     = sel_id;
          irq_vector_d = irq_vec(VEC_BASE, VEC_STRIDE, sel_id);
          state_d      = ST_REQ;
        end
      end
      ST_REQ: begin
        if (irq_ack) begin
          clr         = NUM_SRC'(1) << irq_id_q;
          epc_d       = pc;
          irq_count_d = irq_count_q + 16'd1;
          state_d     = ST_KERNEL;
        end
      end
      ST_KERNEL: begin
        if (kernel_done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new edge on the bit being acknowledged survives the clear.
    pending_d   = (pending_q & ~clr) | rise;
    irq_req_d   = (state_d == ST_REQ);
    in_kernel_d = (state_d == ST_KERNEL);
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q      <= ST_IDLE;
      io_q         <= '0;
      primed_q     <= 1'b0;
      pending_q    <= '0;
      mask_q       <= MASK_RST[NUM_SRC-1:0];
      irq_id_q     <= 4'd0;
      irq_vector_q <= VEC_BASE;
      epc_q        <= 16'd0;
      irq_count_q  <= 16'd0;
      irq_req_q    <= 1'b0;
      in_kernel_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      io_q         <= io_d;
      primed_q     <= primed_d;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      irq_id_q     <= irq_id_d;
      irq_vector_q <= irq_vector_d;
      epc_q        <= epc_d;
      irq_count_q  <= irq_count_d;
      irq_req_q    <= irq_req_d;
      in_kernel_q  <= in_kernel_d;
    end
  end

  assign irq_req    = irq_req_q;
  assign irq_id     = irq_id_q;
  assign irq_vector = irq_vector_q;
  assign epc        = epc_q;
  assign in_kernel  = in_kernel_q;
  assign pending    = pending_q;
  assign mask       = mask_q;
  assign irq_count  = irq_count_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Testbench for interrupt_controller: directed scenarios followed by random
// traffic, all compared against a behavioural model of the controller.
module tb_interrupt_controller;

  logic        CLK;
  logic        Reset;
  logic [15:0] io_in;
  logic        mask_wr;
  logic [15:0] mask_data;
  logic        at_boundary;
  logic [15:0] pc;
  logic        irq_ack;
  logic        kernel_done;
  logic        irq_req;
  logic [3:0]  irq_id;
  logic [15:0] irq_vector;
  logic [15:0] epc;
  logic        in_kernel;
  logic [15:0] pending;
  logic [15:0] mask;
  logic [15:0] irq_count;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  // Behavioural model state
  bit [15:0] m_prev, m_pend, m_mask, m_epc, m_cnt, m_vec;
  int        m_id;
  bit        m_req, m_kern, m_primed;

  interrupt_controller dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .io_in       (io_in),
    .mask_wr     (mask_wr),
    .mask_data   (mask_data),
    .at_boundary (at_boundary),
    .pc          (pc),
    .irq_ack     (irq_ack),
    .kernel_done (kernel_done),
    .irq_req     (irq_req),
    .irq_id      (irq_id),
    .irq_vector  (irq_vector),
    .epc         (epc),
    .in_kernel   (in_kernel),
    .pending     (pending),
    .mask        (mask),
    .irq_count   (irq_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev = 0; m_pend = 0; m_mask = 16'hFFFF; m_epc = 0; m_cnt = 0;
    m_vec = 16'd192; m_id = 0; m_req = 0; m_kern = 0; m_primed = 0;
  endtask

  // One rising edge of the controller as described in words: service the
  // handshake for the current mode, then merge newly posted edges.
  task automatic model_edge();
    bit [15:0] rise, elig, nxt;
    rise = m_primed ? (io_in & ~m_prev) : 16'h0;
    elig = m_pend & m_mask;
    nxt  = m_pend;
    if (m_req) begin
      if (irq_ack) begin
        nxt[m_id] = 1'b0;
        m_epc = pc;
        m_cnt = m_cnt + 16'd1;
        m_req = 0;
        m_kern = 1;
      end
    end else if (m_kern) begin
      if (kernel_done) m_kern = 0;
    end else if (at_boundary && elig != 0) begin
      for (int i = 0; i < 16; i++) begin
        if (elig[i]) begin
          m_id = i;
          break;
        end
      end
      m_vec = 16'(192 + 4 * m_id);
      m_req = 1;
    end
    m_pend = nxt | rise;
    if (mask_wr) m_mask = mask_data;
    m_prev = io_in;
    m_primed = 1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".irq_req"},    32'(irq_req),    32'(m_req));
    chk({tag, ".irq_id"},     32'(irq_id),     32'(m_id));
    chk({tag, ".irq_vector"}, 32'(irq_vector), 32'(m_vec));
    chk({tag, ".epc"},        32'(epc),        32'(m_epc));
    chk({tag, ".in_kernel"},  32'(in_kernel),  32'(m_kern));
    chk({tag, ".pending"},    32'(pending),    32'(m_pend));
    chk({tag, ".mask"},       32'(mask),       32'(m_mask));
    chk({tag, ".irq_count"},  32'(irq_count),  32'(m_cnt));
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset dropped mid-cycle, checked before any clock edge.
  task automatic do_reset(input string tag);
    #2;
    Reset = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    chk({tag, ".req0"},  32'(irq_req),   32'd0);
    chk({tag, ".kern0"}, 32'(in_kernel), 32'd0);
    chk({tag, ".pend0"}, 32'(pending),   32'd0);
    @(negedge CLK);
    Reset = 1'b1;
  endtask

  initial begin
    Reset = 1'b1; io_in = 0; mask_wr = 0; mask_data = 0;
    at_boundary = 0; pc = 0; irq_ack = 0; kernel_done = 0;
    model_reset();

    // 1: reset values, then a single rising edge
    #2;
    Reset = 1'b0;
    io_in = 16'h0004;
    #5;
    check_all("t1_rst");
    chk("t1_mask", 32'(mask), 32'hFFFF);
    chk("t1_vec",  32'(irq_vector), 32'd192);
    io_in = 16'h0000;
    @(negedge CLK);
    Reset = 1'b1;
    step("t1_prime");
    io_in = 16'h0004;
    step("t1_edge");
    chk("t1_pend", 32'(pending), 32'h0004);

    // 2: entry and acknowledge
    at_boundary = 1;
    step("t2_req");
    chk("t2_id",  32'(irq_id), 32'd2);
    chk("t2_vec", 32'(irq_vector), 32'd200);
    at_boundary = 0; irq_ack = 1; pc = 16'h0031;
    step("t2_ack");
    chk("t2_epc", 32'(epc), 32'h0031);
    chk("t2_cnt", 32'(irq_count), 32'd1);
    irq_ack = 0;

    // 3: priority between bits 1 and 5
    io_in = 16'h0026;
    step("t3_edges");
    kernel_done = 1;
    step("t3_done");
    kernel_done = 0; at_boundary = 1;
    step("t3_req1");
    chk("t3_id1", 32'(irq_id), 32'd1);
    at_boundary = 0; irq_ack = 1; pc = 16'h0100;
    step("t3_ack1");
    irq_ack = 0; kernel_done = 1;
    step("t3_done1");
    kernel_done = 0; at_boundary = 1;
    step("t3_req5");
    chk("t3_id5",  32'(irq_id), 32'd5);
    chk("t3_vec5", 32'(irq_vector), 32'd212);
    at_boundary = 0; irq_ack = 1; pc = 16'h0200;
    step("t3_ack5");
    irq_ack = 0; kernel_done = 1;
    step("t3_done5");
    kernel_done = 0;

    // 4: masking and unmasking
    mask_wr = 1; mask_data = 16'hFFFD;
    step("t4_mask");
    mask_wr = 0; io_in = 16'h0024;
    step("t4_low");
    io_in = 16'h0026;
    step("t4_rise");
    chk("t4_pend", 32'(pending), 32'h0002);
    at_boundary = 1;
    step("t4_masked");
    chk("t4_noreq", 32'(irq_req), 32'd0);
    mask_wr = 1; mask_data = 16'hFFFF;
    step("t4_unmask");
    mask_wr = 0;
    step("t4_req");
    chk("t4_req1", 32'(irq_req), 32'd1);

    // 5: stray pulses and edges while in kernel
    at_boundary = 0; kernel_done = 1;
    step("t5_stray_done");
    chk("t5_still_req", 32'(irq_req), 32'd1);
    kernel_done = 0; irq_ack = 1;
    step("t5_ack");
    irq_ack = 0; io_in = 16'h002E; at_boundary = 1;
    step("t5_bit3");
    chk("t5_pend3", 32'(pending[3]), 32'd1);
    step("t5_hold");
    chk("t5_kern", 32'(in_kernel), 32'd1);
    irq_ack = 1;
    step("t5_stray_ack");
    chk("t5_cnt", 32'(irq_count), 32'd4);
    irq_ack = 0; kernel_done = 1;
    step("t5_done");
    kernel_done = 0;
    step("t5_req3");
    chk("t5_id3", 32'(irq_id), 32'd3);

    // 6: asynchronous reset in REQ and in KERNEL, lines held high
    do_reset("t6_rst_req");
    step("t6_held0");
    step("t6_held1");
    step("t6_held2");
    chk("t6_nopost", 32'(pending), 32'd0);
    io_in = 16'h002F;
    step("t6_toggle");
    step("t6_req");
    irq_ack = 1; at_boundary = 0;
    step("t6_ack");
    irq_ack = 0;
    do_reset("t6_rst_kern");

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      io_in       = io_in ^ 16'($urandom & $urandom & $urandom);
      at_boundary = ($urandom_range(0, 1) == 1);
      irq_ack     = ($urandom_range(0, 3) == 0);
      kernel_done = ($urandom_range(0, 3) == 0);
      mask_wr     = ($urandom_range(0, 15) == 0);
      mask_data   = 16'($urandom);
      pc          = 16'($urandom);
      step("rnd");
      if (n % 700 == 350) do_reset("rnd_rst");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Sits between the `io_in` request lines and `control_unit`. Owns the kernel-entry sequence for the "Frankie" CPU.
- Edge-detects and latches requests, applies a software mask, picks one source by fixed priority, and asks the control unit for entry at an instruction boundary.
- On the control unit's acknowledge it tracks kernel mode until the return-from-kernel pulse.
- Replaces raw `io_in != 0` level checks in the control path.

Parameters:
- `NUM_SRC`, 16, number of interrupt request lines (max 16).
- `VEC_BASE`, 16'd192, kernel vector for source 0.
- `VEC_STRIDE`, 16'd4, vector spacing per source index.
- `MASK_RST`, 16'hFFFF, mask value after reset (1 = enabled).

Ports:
- `CLK`  in  1  system clock, all state updates on rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `io_in`  in  NUM_SRC  raw request lines, level; a 0→1 transition posts a request.
- `mask_wr`  in  1  one-cycle strobe; load `mask_data` into mask.
- `mask_data`  in  NUM_SRC  new mask value.
- `at_boundary`  in  1  high when control unit is in Fetch (instruction boundary).
- `pc`  in  16  current PC, captured on acknowledge.
- `irq_ack`  in  1  control unit entering kernel (Fifth state).
- `kernel_done`  in  1  one-cycle pulse on return from kernel (PC==255 path).
- `irq_req`  out  1  interrupt entry requested.
- `irq_id`  out  4  index of selected source.
- `irq_vector`  out  16  `VEC_BASE + irq_id*VEC_STRIDE`, truncated to 16 bits.
- `epc`  out  16  PC captured at acknowledge.
- `in_kernel`  out  1  kernel mode active.
- `pending`  out  NUM_SRC  latched request bits.
- `mask`  out  NUM_SRC  current mask.
- `irq_count`  out  16  serviced-interrupt counter, wraps at 16'hFFFF→0.

Behaviour:

Reset:
- Reset low (asynchronous): state=IDLE; `io_q`, `pending`, `irq_id`, `epc`, `irq_count` = 0.
- `mask`=MASK_RST, `irq_req`=0, `in_kernel`=0, `irq_vector`=VEC_BASE.
- Reset asserted mid-operation (REQ or KERNEL) aborts immediately to these values.

Edge detect and pending:
- `io_q` <= `io_in` every cycle.
- `rise = io_in & ~io_q`; `pending[i]` set on the posedge where `rise[i]`=1. Visible the next cycle (latency 1).
- A line held high posts exactly one request.
- `pending[i]` cleared only on acknowledge of source i. If a set and a clear of the same bit coincide, set wins.

Mask:
- Written on `mask_wr`; takes effect the next cycle.
- Masking does not clear pending bits; unmasking a pending bit makes it eligible.

Selection:
- `eligible = pending & mask`.
- Lowest-index set bit wins (bit 0 highest priority).

FSM states: IDLE, REQ, KERNEL. Outputs are registered/Moore.
- IDLE:
  - If `eligible != 0` and `at_boundary`=1: latch `irq_id`/`irq_vector` from the selection and go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - `irq_req`=1; `irq_id`/`irq_vector` held frozen even if mask or pending change.
  - On `irq_ack`=1: clear `pending[irq_id]`, `epc<=pc`, `irq_count+1`, go to KERNEL.
  - `kernel_done` is ignored.
- KERNEL:
  - `in_kernel`=1, `irq_req`=0.
  - New edges still latch into `pending` but are not selected.
  - On `kernel_done`=1: go to IDLE with `in_kernel`=0. A new request may be raised on the next boundary, earliest 1 cycle later.

Timing and illegal inputs:
- `irq_req` rises the cycle after the boundary sample.
- `in_kernel` rises the cycle after `irq_ack`.
- `irq_ack` outside REQ and `kernel_done` outside KERNEL: ignored, no state change.
- Simultaneous `irq_ack` and `kernel_done` in REQ: ack taken, done ignored.

Decomposition:
- Shared package `frankie_pkg`:
  - FSM state encoding (IDLE=0, REQ=1, KERNEL=2).
  - `KERNEL_RET_PC` = 255.
  - Default `VEC_BASE`/`VEC_STRIDE`.
- One sub-module: `irq_prio_enc`. Combinational NUM_SRC→4-bit lowest-set-bit encoder plus `any` flag.

Test Plan:
1. Reset low with `io_in`=16'h0004 → all outputs at reset values, `mask`=16'hFFFF. Release reset, then `io_in` 0→4 → `pending`=16'h0004 the next cycle.
2. `pending`=16'h0004, `at_boundary`=1 → `irq_req`=1, `irq_id`=2, `irq_vector`=200. `irq_ack` with `pc`=16'h0031 → `pending`=0, `epc`=16'h0031, `in_kernel`=1, `irq_count`=1.
3. Bits 5 and 1 rise together → `irq_id`=1 first. After `kernel_done` and the next boundary → `irq_id`=5, vector 212.
4. `mask_wr` with `mask_data`=16'hFFFD, then bit 1 rises → `pending`=16'h0002, `irq_req` stays 0. Unmask → `irq_req`=1 at the next boundary.
5. In KERNEL, bit 3 rises; `kernel_done` also pulsed during IDLE/REQ → `pending[3]`=1, no re-entry until after the genuine `kernel_done`. Stray pulses cause no state change.
6. Reset asserted while in REQ and while in KERNEL → `irq_req`=0 and `in_kernel`=0 immediately (asynchronous), `pending`=0. Line held high after release posts no request until it toggles.
